// File: rtl/zbt_sram_ctrl_if.sv
// Request/response and ZBT pin bundle for zbt_sram_ctrl.
// master = on-chip requester plus the board side of the DQ buffer; slave = the controller.
interface zbt_sram_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic [3:0]        sram_bw_n;
  logic              sram_adv_ld_n;
  logic              sram_oe_n;
  logic              sram_zz;
  logic [31:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [31:0]       sram_dq_i;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, sram_dq_i,
    input  req_ready, rd_valid, rd_data, sram_addr, sram_ce_n, sram_we_n,
           sram_bw_n, sram_adv_ld_n, sram_oe_n, sram_zz, sram_dq_o, sram_dq_oe
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, sram_dq_i,
    output req_ready, rd_valid, rd_data, sram_addr, sram_ce_n, sram_we_n,
           sram_bw_n, sram_adv_ld_n, sram_oe_n, sram_zz, sram_dq_o, sram_dq_oe
  );
endinterface

// File: rtl/zbt_sram_ctrl.sv
// Pipelined ZBT SRAM controller: single-word requests, fixed 4-cycle read latency,
// registered SRAM pins and idle-driven snooze with a wake delay.
module zbt_sram_ctrl #(
  parameter int ADDR_W       = 17,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int WAKE_CYCLES  = 2
) (
  input  logic          clk,
  input  logic          reset,
  zbt_sram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_t;

  localparam bit SNOOZE_EN = (IDLE_TIMEOUT != 0);
  localparam int IDLE_W    = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int WAKE_W    = (WAKE_CYCLES > 2) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    (IDLE_TIMEOUT > 0) ? IDLE_W'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [WAKE_W-1:0] WAKE_LAST =
    (WAKE_CYCLES > 0) ? WAKE_W'(WAKE_CYCLES - 1) : '0;

  state_t              r_state;
  state_t              w_next;
  logic [IDLE_W-1:0]   r_idle;
  logic [WAKE_W-1:0]   r_wake;
  logic                w_ready;
  logic                w_accept;
  logic                w_pipe_empty;

  logic                r_ce_n;
  logic                r_we_n;
  logic [3:0]          r_bw_n;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_oe_n;
  logic                r_zz;

  logic [31:0]         r_wd1;
  logic [31:0]         r_wd2;
  logic [31:0]         r_dq_o;
  logic                r_wtag1;
  logic                r_wtag2;
  logic                r_dq_oe;

  logic                r_rtag1;
  logic                r_rtag2;
  logic                r_rtag3;
  logic                r_rd_valid;
  logic [31:0]         r_rd_data;

  assign w_ready      = (r_state == RUN) && !reset;
  assign w_accept     = w_ready && bus.req_valid;
  assign w_pipe_empty = ~|{r_wtag1, r_wtag2, r_dq_oe, r_rtag1, r_rtag2, r_rtag3};

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (SNOOZE_EN && !w_accept && (r_idle == IDLE_LAST)) w_next = DRAIN;
      DRAIN:   if (w_pipe_empty) w_next = SLEEP;
      SLEEP:   if (bus.req_valid) w_next = WAKE;
      WAKE:    if (r_wake == WAKE_LAST) w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // oe_n/zz are registered from the next state, so they track the state
  // cycle-for-cycle except that reset forces oe_n high for one extra cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_idle     <= '0;
      r_wake     <= '0;
      r_ce_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_bw_n     <= '1;
      r_addr     <= '0;
      r_oe_n     <= 1'b1;
      r_zz       <= 1'b0;
      r_wd1      <= '0;
      r_wd2      <= '0;
      r_dq_o     <= '0;
      r_wtag1    <= 1'b0;
      r_wtag2    <= 1'b0;
      r_dq_oe    <= 1'b0;
      r_rtag1    <= 1'b0;
      r_rtag2    <= 1'b0;
      r_rtag3    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state <= w_next;
      r_idle  <= (SNOOZE_EN && r_state == RUN && w_next == RUN && !w_accept)
                 ? r_idle + IDLE_W'(1) : '0;
      r_wake  <= (r_state == WAKE && w_next == WAKE) ? r_wake + WAKE_W'(1) : '0;

      r_ce_n <= !w_accept;
      r_we_n <= !(w_accept && bus.req_we);
      r_bw_n <= (w_accept && bus.req_we) ? ~bus.req_be : 4'hF;
      if (w_accept) r_addr <= bus.req_addr;
      r_oe_n <= (w_next == SLEEP);
      r_zz   <= (w_next == SLEEP);

      r_wd1   <= bus.req_wdata;
      r_wd2   <= r_wd1;
      r_dq_o  <= r_wd2;
      r_wtag1 <= w_accept && bus.req_we;
      r_wtag2 <= r_wtag1;
      r_dq_oe <= r_wtag2;

      r_rtag1    <= w_accept && !bus.req_we;
      r_rtag2    <= r_rtag1;
      r_rtag3    <= r_rtag2;
      r_rd_valid <= r_rtag3;
      if (r_rtag3) r_rd_data <= bus.sram_dq_i;
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.rd_data       = r_rd_data;
  assign bus.sram_addr     = r_addr;
  assign bus.sram_ce_n     = r_ce_n;
  assign bus.sram_we_n     = r_we_n;
  assign bus.sram_bw_n     = r_bw_n;
  assign bus.sram_adv_ld_n = 1'b0;
  assign bus.sram_oe_n     = r_oe_n;
  assign bus.sram_zz       = r_zz;
  assign bus.sram_dq_o     = r_dq_o;
  assign bus.sram_dq_oe    = r_dq_oe;

endmodule

// File: doc/zbt_sram_ctrl.md
# zbt_sram_ctrl

Pipelined ZBT SRAM controller that issues real read and write cycles on the external 32-bit ZBT interface, replacing the static tie-offs on the chip-enable, write, byte-write, output-enable and snooze pins. It accepts single-word requests over a valid/ready handshake from on-chip logic and returns read data with fixed latency. It manages the two-cycle ZBT data pipeline, drives the data-bus output enable, and puts the SRAM into snooze mode after a programmable idle period. `sram_lbo_n` and `sram_cke_n` remain tied low at top level.

## Interface
- ADDR_W, 17, SRAM word address width
- IDLE_TIMEOUT, 1024, idle cycles in RUN before snooze entry; 0 disables snooze
- WAKE_CYCLES, 2, cycles `zz` is held low before requests are accepted again; must be ≥1

- clk  in  1  single system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  32  write data
- req_be  in  4  byte enables, active high; bit 0 = byte A
- rd_valid  out  1  single-cycle read-data strobe
- rd_data  out  32  read data, valid only while `rd_valid`=1
- sram_addr  out  ADDR_W  registered address
- sram_ce_n  out  1  chip enable, active low
- sram_we_n  out  1  write enable, active low
- sram_bw_n  out  4  byte-write enables, active low
- sram_adv_ld_n  out  1  held 0 (load new address every cycle)
- sram_oe_n  out  1  output enable, active low
- sram_zz  out  1  snooze
- sram_dq_o  out  32  write data to the I/O buffer
- sram_dq_oe  out  1  1 = FPGA drives DQ
- sram_dq_i  in  32  data from the I/O buffer

## Operation
- **FSM states:** RUN, DRAIN, SLEEP, WAKE. Reset enters RUN.
- **Handshake:**
  - `req_ready` = 1 only in RUN, and never during a reset cycle.
  - A request is accepted on any edge where `req_valid` and `req_ready` are both 1.
  - Back-to-back accepts at one per cycle are supported; there is no read/write turnaround bubble.
- **Command cycle (accepted request):**
  - `sram_ce_n`=0.
  - `sram_we_n` = ~`req_we`.
  - `sram_bw_n` = ~`req_be` for writes, 4'hF for reads.
  - `sram_addr` = `req_addr`.
- **NOP cycle (no accept):** `sram_ce_n`=1, `sram_we_n`=1, `sram_bw_n`=4'hF; `sram_addr` holds its last value.
- **Write data pipeline:**
  - `req_wdata` passes through a 2-stage register chain to `sram_dq_o`.
  - A matching 2-stage write-tag pipeline drives `sram_dq_oe`.
- **Read tag pipeline:**
  - A 3-stage tag pipeline captures `sram_dq_i` into `rd_data` and pulses `rd_valid`.
  - Reads complete strictly in issue order.
- **Idle counter:**
  - Counts RUN cycles with no accept; it clears on any accept.
  - When it reaches IDLE_TIMEOUT (with IDLE_TIMEOUT≠0), the FSM goes to DRAIN.
- **DRAIN:**
  - `req_ready`=0; no new commands are issued.
  - The FSM waits until the write and read tag pipelines are empty, then goes to SLEEP.
- **SLEEP:**
  - `sram_zz`=1, `sram_oe_n`=1, `sram_ce_n`=1.
  - `req_valid`=1 moves the FSM to WAKE. The request is not accepted; it stays pending.
- **WAKE:**
  - `sram_zz`=0; `req_ready`=0.
  - After WAKE_CYCLES cycles the FSM returns to RUN and the idle counter is cleared.
- **`sram_oe_n`:** 0 in RUN, DRAIN and WAKE; 1 in SLEEP and in reset.
- **Reset mid-operation:** all pipelines are flushed. In-flight reads never produce `rd_valid`, and in-flight writes never assert `sram_dq_oe`.

## Timing
- **Reset values (outputs, cycle after reset asserted):**
  - `req_ready`=0, `rd_valid`=0, `rd_data`=0.
  - `sram_ce_n`=1, `sram_we_n`=1, `sram_bw_n`=4'hF, `sram_addr`=0.
  - `sram_adv_ld_n`=0, `sram_oe_n`=1, `sram_zz`=0.
  - `sram_dq_o`=0, `sram_dq_oe`=0.
- **`req_ready` after reset:** 1 in the first cycle after reset deasserts.
- All SRAM outputs are registered (IOB flops).
- **Latency (request accepted at edge E):**
  - Command pins are valid in the cycle after E (C1).
  - Write: `sram_dq_o`/`sram_dq_oe`=1 in cycle C3, exactly 2 cycles after the command, for one cycle.
  - Read: the SRAM drives DQ in C3, `sram_dq_i` is sampled at the end of C3, and `rd_valid`=1 in C4.
  - Read latency from accept to `rd_valid` is therefore 4 cycles.
- **Alternating traffic:** `sram_dq_oe` may toggle every cycle; the ZBT pipeline guarantees no bus contention.
- **IDLE_TIMEOUT boundary:**
  - With IDLE_TIMEOUT=N, the Nth consecutive idle RUN cycle is the last with `req_ready`=1.
  - An accept on that same cycle wins: the counter clears and the FSM stays in RUN.
- **Sleep timing:**
  - DRAIN lasts at least 1 cycle and at most 4 cycles.
  - SLEEP→WAKE→RUN: `req_ready` returns WAKE_CYCLES+1 cycles after the SLEEP cycle that sees `req_valid`.

## Test plan
- Reset, then write A=0x00010 D=0xDEADBEEF be=4'hF.
  - C1: `ce_n`=0, `we_n`=0, `bw_n`=0.
  - C3: `dq_oe`=1, `dq_o`=0xDEADBEEF.
- Read A=0x00010 with the SRAM model returning 0xDEADBEEF → `rd_valid` exactly 4 cycles after accept, `rd_data`=0xDEADBEEF.
- Back-to-back W(0x1,be=4'h3), R(0x1), W(0x2), R(0x2) on consecutive cycles.
  - `req_ready` never drops.
  - `dq_oe` pattern 1,0,1,0 starting C3.
  - Two `rd_valid` pulses, in order.
- IDLE_TIMEOUT=8, WAKE_CYCLES=2, no traffic:
  - DRAIN is entered, then `zz`=1 and `oe_n`=1.
  - On `req_valid`, `zz`→0 and `req_ready`=1 3 cycles later; the pending read then completes normally.
- Issue 3 reads, assert `reset` 2 cycles after the last accept → no `rd_valid` ever, and all outputs at their reset values the next cycle.
- IDLE_TIMEOUT=0, 5000 idle cycles → `zz` stays 0 and `req_ready` stays 1.
